// File: rtl/vrf_wb_arbiter.sv
// Write-back arbiter for the vector register file write port: two requesters
// (ALU result, load return), round-robin on conflict, registered port outputs.
module vrf_wb_arbiter #(
  parameter int WIDTH_ADDR   = 4,
  parameter int WIDTH_VECTOR = 8,
  parameter int N            = 32,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic [WIDTH_ADDR-1:0]             req0_addr,
  input  logic [WIDTH_VECTOR-1:0]           req0_mask,
  input  logic [WIDTH_VECTOR-1:0][N-1:0]    req0_data,
  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic [WIDTH_ADDR-1:0]             req1_addr,
  input  logic [WIDTH_VECTOR-1:0]           req1_mask,
  input  logic [WIDTH_VECTOR-1:0][N-1:0]    req1_data,
  output logic [WIDTH_VECTOR-1:0]           wec,
  output logic [WIDTH_ADDR-1:0]             addrc,
  output logic [WIDTH_VECTOR-1:0][N-1:0]    wdata_c,
  output logic                              wr_busy,
  output logic [CNT_W-1:0]                  conflict_cnt
);

  // Handshake: a write transfers on a rising edge where reqX_valid & reqX_ready.
  // reqX_ready depends only on the two valids and last_grant, so a requester
  // holds valid and payload stable until it sees ready.

  logic                           last_grant_q, last_grant_d;
  logic [WIDTH_VECTOR-1:0]        wec_q, wec_d;
  logic [WIDTH_ADDR-1:0]          addrc_q, addrc_d;
  logic [WIDTH_VECTOR-1:0][N-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  logic gnt0, gnt1, both_valid;

  // last_grant_q == 1 means requester 1 won last, so requester 0 wins the tie.
  always_comb begin
    both_valid = req0_valid & req1_valid;
    gnt0       = req0_valid & (~req1_valid | last_grant_q);
    gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = gnt0 & ~rst;
  assign req1_ready = gnt1 & ~rst;

  always_comb begin
    last_grant_d = last_grant_q;
    wec_d        = '0;
    addrc_d      = addrc_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if (gnt0) begin
      wec_d        = req0_mask;
      addrc_d      = req0_addr;
      wdata_d      = req0_data;
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      wec_d        = req1_mask;
      addrc_d      = req1_addr;
      wdata_d      = req1_data;
      last_grant_d = 1'b1;
    end
    if (both_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      wec_q        <= '0;
      addrc_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wec_q        <= wec_d;
      addrc_q      <= addrc_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wec          = wec_q;
  assign addrc        = addrc_q;
  assign wdata_c      = wdata_q;
  assign wr_busy      = |wec_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Bench for vrf_wb_arbiter: queue-based requesters, behavioural model, RAM-side
// scoreboard, plus a small-counter instance to exercise saturation.
module tb_vrf_wb_arbiter;
  localparam int WA = 4;
  localparam int WV = 8;
  localparam int NB = 32;
  localparam int DW = WV * NB;
  localparam int W  = WA + WV + DW;

  typedef struct packed {
    logic [WA-1:0] addr;
    logic [WV-1:0] mask;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [WA-1:0] req0_addr = '0, req1_addr = '0;
  logic [WV-1:0] req0_mask = '0, req1_mask = '0;
  logic [WV-1:0][NB-1:0] req0_data = '0, req1_data = '0;
  logic [WV-1:0] wec;
  logic [WA-1:0] addrc;
  logic [WV-1:0][NB-1:0] wdata_c;
  logic wr_busy;
  logic [15:0] conflict_cnt;

  logic r0_2, r1_2, busy_2;
  logic [WV-1:0] wec_2;
  logic [WA-1:0] addrc_2;
  logic [WV-1:0][NB-1:0] wdata_2;
  logic [1:0] cnt_2;

  vrf_wb_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_mask(req0_mask), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_mask(req1_mask), .req1_data(req1_data),
    .wec(wec), .addrc(addrc), .wdata_c(wdata_c), .wr_busy(wr_busy),
    .conflict_cnt(conflict_cnt)
  );

  vrf_wb_arbiter #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0_2), .req0_addr(req0_addr),
    .req0_mask(req0_mask), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(r1_2), .req1_addr(req1_addr),
    .req1_mask(req1_mask), .req1_data(req1_data),
    .wec(wec_2), .addrc(addrc_2), .wdata_c(wdata_2), .wr_busy(busy_2),
    .conflict_cnt(cnt_2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  bit            m_last = 1'b1;
  logic [WV-1:0] m_wec  = '0;
  logic [WA-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt  = 0;
  int            m_cnt2 = 0;

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_last = 1'b1; m_wec = '0; m_addr = '0; m_data = '0;
      m_cnt = 0; m_cnt2 = 0;
      exp_q.delete();
    end else begin
      if (req0_valid && req1_valid) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      g = -1;
      if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g == 0) begin
        m_wec = req0_mask; m_addr = req0_addr; m_data = req0_data; m_last = 1'b0;
      end else if (g == 1) begin
        m_wec = req1_mask; m_addr = req1_addr; m_data = req1_data; m_last = 1'b1;
      end else begin
        m_wec = '0;
      end
      if (g >= 0 && m_wec != '0) exp_q.push_back({m_addr, m_wec, m_data});
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_r0, e_r1;
    e_r0 = !rst && req0_valid && (!req1_valid || m_last);
    e_r1 = !rst && req1_valid && (!req0_valid || !m_last);
    check("req0_ready", req0_ready, e_r0);
    check("req1_ready", req1_ready, e_r1);
    check("wec", wec, m_wec);
    check("addrc", addrc, m_addr);
    check("wdata_c", wdata_c, m_data);
    check("wr_busy", wr_busy, (m_wec != '0));
    check("conflict_cnt", conflict_cnt, m_cnt);
    check("cnt2", cnt_2, m_cnt2);
    check("dut2_port", {r0_2, r1_2, busy_2, wec_2, addrc_2, wdata_2},
          {e_r0, e_r1, (m_wec != '0), m_wec, m_addr, m_data});
  end

  // RAM-side scoreboard: every write the RAM captures must be the next expected one.
  int ram_writes = 0;
  always @(posedge clk) begin
    if (wec !== '0) begin
      ram_writes++;
      if (exp_q.size() == 0) begin
        check("ram_unexpected", {addrc, wec, wdata_c}, '0);
      end else begin
        check("ram_write", {addrc, wec, wdata_c}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  wr_t q0[$];
  wr_t q1[$];

  task automatic drive_heads();
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_addr = q0[0].addr; req0_mask = q0[0].mask; req0_data = q0[0].data;
    end else req0_valid = 1'b0;
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_addr = q1[0].addr; req1_mask = q1[0].mask; req1_data = q1[0].data;
    end else req1_valid = 1'b0;
  endtask

  task automatic cycle();
    logic a0, a1;
    @(posedge clk);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive_heads();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_budget", q0.size() + q1.size(), 0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic wr_t rand_wr(input bit allow_zero_mask);
    wr_t w;
    w.addr = WA'($urandom_range(0, 15));
    w.mask = WV'($urandom);
    if (allow_zero_mask && $urandom_range(0, 3) == 0) w.mask = '0;
    for (int i = 0; i < WV; i++) w.data[i*NB +: NB] = $urandom;
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    wr_t w;
    logic [DW-1:0] lanes;
    for (int i = 0; i < WV; i++) lanes[i*NB +: NB] = 32'h11 * (i + 1);

    // reset with both valids raised: no ready, no write, no count
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_wec", wec, '0);
    check("rst_cnt", conflict_cnt, '0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    check("idle_wec", wec, '0);

    // single req0 write, all lanes
    w.addr = 4'd3; w.mask = 8'hFF; w.data = lanes;
    q0.push_back(w);
    drive_heads();
    #1 check("single_ready_same_cycle", req0_ready, 1'b1);
    cycle();
    check("single_wec", wec, 8'hFF);
    check("single_addr", addrc, 4'd3);
    check("single_data", wdata_c, lanes);
    cycle();
    check("single_wec_pulse_end", wec, '0);

    // conflict after reset: grants 0,1,0 and two conflict cycles
    do_reset();
    w = rand_wr(0); w.mask = 8'hFF; w.addr = 4'd1; q0.push_back(w);
    w = rand_wr(0); w.mask = 8'hFF; w.addr = 4'd2; q0.push_back(w);
    w = rand_wr(0); w.mask = 8'hFF; w.addr = 4'd9; q1.push_back(w);
    drive_heads();
    cycle(); check("rr_first", addrc, 4'd1);
    cycle(); check("rr_second", addrc, 4'd9);
    cycle(); check("rr_third", addrc, 4'd2);
    check("rr_cnt", conflict_cnt, 16'd2);
    cycle();

    // zero-mask write from req1 still moves the pointer
    w = rand_wr(0); w.mask = 8'h00; w.addr = 4'd5; q1.push_back(w);
    drive_heads();
    #1 check("zmask_ready", req1_ready, 1'b1);
    cycle();
    check("zmask_wec", wec, '0);
    w = rand_wr(0); w.mask = 8'h3C; w.addr = 4'd6; q0.push_back(w);
    w = rand_wr(0); w.mask = 8'hC3; w.addr = 4'd7; q1.push_back(w);
    drive_heads();
    cycle();
    check("zmask_then_req0", addrc, 4'd6);
    drain(10);

    // sustained conflict: 4 writes each, 7 dual-valid edges
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_wr(0));
      q1.push_back(rand_wr(0));
    end
    drive_heads();
    drain(20);
    check("sustain_cnt", conflict_cnt, 16'd7);
    check("sustain_cnt2_sat", cnt_2, 2'd3);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(rand_wr(1));
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(rand_wr(1));
      drive_heads();
      cycle();
    end
    drain(20);
    cycle();

    // reset during the cycle after a write is accepted: write is dropped
    w = rand_wr(0); w.mask = 8'h0F; w.addr = 4'd4; q0.push_back(w);
    drive_heads();
    cycle();
    check("midrst_wec_before", wec, 8'h0F);
    #1 rst = 1'b1;
    #1 check("midrst_wec_cleared", wec, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    check("midrst_ptr_reset_cnt", conflict_cnt, '0);

    repeat (2) cycle();
    check("exp_q_empty", exp_q.size(), 0);
    check("ram_writes_seen", (ram_writes > 100), 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
